// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle 8-bit unsigned multiply/divide execution unit.
//            Captures two register-file operands, iterates one bit per cycle
//            (8 iterations), then drives one register-file write-back pulse.
//            Single-issue; busy lets the sequencer stall.
// Ports    : clk, rst (async, active-high)
//            start, op[1:0], src_a[7:0], src_b[7:0], dst_in[3:0], flush
//            busy, wb_we, wb_dst[3:0], wb_data[7:0]
//            op: 00 MULL, 01 MULH, 10 DIVQ, 11 DIVR
// Config   : MULDIV_DIV_EN - when defined the divider datapath is built;
//            otherwise DIVQ/DIVR complete with identical timing and
//            write back 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] src_a,
    input  logic [7:0] src_b,
    input  logic [3:0] dst_in,
    input  logic       flush,
    output logic       busy,
    output logic       wb_we,
    output logic [3:0] wb_dst,
    output logic [7:0] wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  dst_q, dst_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic        wb_we_q, wb_we_d;
    logic [3:0]  wb_dst_q, wb_dst_d;
    logic [7:0]  wb_data_q, wb_data_d;

    // Shift-add step: add A shifted by the iteration index when that bit of B is set.
    logic [15:0] w_addend;
    logic [15:0] w_acc_next;
    assign w_addend   = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
    assign w_acc_next = acc_q + w_addend;

`ifdef MULDIV_DIV_EN
    logic [7:0] rem_q, rem_d;
    logic [7:0] quo_q, quo_d;
    logic [8:0] w_shift;
    logic [8:0] w_diff;
    logic       w_ge;
    logic [7:0] w_rem_next;
    logic [7:0] w_quo_next;

    // MSB-first: iteration k brings in dividend bit 7-k (== ~k for 3 bits).
    assign w_shift = {rem_q, a_q[~cnt_q]};
    assign w_diff  = w_shift - {1'b0, b_q};
    // The restored remainder is always below the divisor (or is a dividend
    // prefix when dividing by zero), so the shifted value never reaches
    // divisor+256 and bit 8 of the difference is exactly the borrow.
    assign w_ge       = ~w_diff[8];
    assign w_rem_next = w_ge ? w_diff[7:0] : w_shift[7:0];
    assign w_quo_next = {quo_q[6:0], w_ge};
`endif

    logic [7:0] w_result;
    always_comb begin
        w_result = 8'h00;
        case (op_q)
            2'b00:   w_result = w_acc_next[7:0];
            2'b01:   w_result = w_acc_next[15:8];
`ifdef MULDIV_DIV_EN
            2'b10:   w_result = w_quo_next;
            default: w_result = w_rem_next;
`else
            default: w_result = 8'h00;
`endif
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dst_d     = dst_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        wb_we_d   = 1'b0;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
`ifdef MULDIV_DIV_EN
        rem_d     = rem_q;
        quo_d     = quo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // flush has priority: a simultaneous request is dropped.
                if (start && !flush) begin
                    state_d = ST_CALC;
                    cnt_d   = 3'd0;
                    op_d    = op;
                    dst_d   = dst_in;
                    a_d     = src_a;
                    b_d     = src_b;
                    acc_d   = 16'h0000;
`ifdef MULDIV_DIV_EN
                    rem_d   = 8'h00;
                    quo_d   = 8'h00;
`endif
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    acc_d = w_acc_next;
`ifdef MULDIV_DIV_EN
                    rem_d = w_rem_next;
                    quo_d = w_quo_next;
`endif
                    if (cnt_q == LAST_ITER) begin
                        state_d   = ST_WB;
                        wb_we_d   = 1'b1;
                        wb_dst_d  = dst_q;
                        wb_data_d = w_result;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            op_q      <= 2'b00;
            dst_q     <= 4'h0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            acc_q     <= 16'h0000;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= 4'h0;
            wb_data_q <= 8'h00;
`ifdef MULDIV_DIV_EN
            rem_q     <= 8'h00;
            quo_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
`ifdef MULDIV_DIV_EN
            rem_q     <= rem_d;
            quo_q     <= quo_d;
`endif
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wb_we   = wb_we_q;
    assign wb_dst  = wb_dst_q;
    assign wb_data = wb_data_q;

endmodule
`default_nettype wire
